fp_add_pipe: RTL and testbench

//  Parametrised, 3-stage pipelined IEEE-754-style floating-point adder/subtractor for the CNN datapath.
//  It succeeds the single-precision fp_add_2, adding the following:
//   - generic exponent/mantissa widths and a subtract mode;
//   - round-to-nearest-even, special-value handling and exception flags;
//   - a valid/ready handshake with full backpressure.
//  Its consumers are the MAC/accumulate stage and the bias-add in conv/FC layers.

---
 rtl/fp_add_pipe_pkg.sv | 24 ++
 rtl/fp_add_pipe_lzc.sv | 18 +
 rtl/fp_add_pipe.sv | 195 +++++++++++++++++++
 tb/tb_fp_add_pipe.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_add_pipe_pkg.sv
// Shared definitions for the pipelined floating-point adder: operand classes,
// flag bit positions and the operand classifier.
package fp_add_pipe_pkg;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_class_e;

  localparam int unsigned FLG_INVALID  = 2;
  localparam int unsigned FLG_OVERFLOW = 1;
  localparam int unsigned FLG_INEXACT  = 0;

  // Denormals (exp == 0) are deliberately folded into CLS_ZERO.
  function automatic fp_class_e fp_classify(input logic exp_ones, input logic exp_zero,
                                             input logic frac_zero);
    if (exp_zero) return CLS_ZERO;
    if (exp_ones) return frac_zero ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction

endpackage

// File: rtl/fp_add_pipe_lzc.sv
// Parametrised leading-zero counter; an all-zero input returns WIDTH.
module fp_lzc #(
  parameter int WIDTH = 27,
  parameter int CNT_W = 5
) (
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] count
);

  // Scan upward so the most significant set bit is the last one to win.
  always_comb begin
    count = CNT_W'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (data[i]) count = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_add_pipe.sv
// 3-stage pipelined floating-point adder/subtractor with RNE rounding,
// special-value handling, exception flags and a globally stalled handshake.
module fp_add_pipe
  import fp_add_pipe_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   A_FP,
  input  logic [EXP_W+MAN_W:0]   B_FP,
  input  logic                   op_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   sign,
  output logic [EXP_W-1:0]       exponent,
  output logic [MAN_W-1:0]       mantissa,
  output logic [2:0]             flags
);

  localparam int W  = EXP_W + MAN_W + 1;
  localparam int XW = MAN_W + 4;            // hidden + fraction + G/R/S
  localparam int CW = $clog2(XW + 1);
  localparam int EW = EXP_W + 2;            // room for carry and negative exponents
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic advance;
  assign in_ready = ~out_valid | out_ready;
  assign advance  = in_ready;

  // ---------------- S1: classify, swap, align ----------------
  logic             a_s, b_s, x_s, y_s, swap;
  logic [EXP_W-1:0] a_e, b_e, x_e, y_e, shift;
  fp_class_e        a_cls, b_cls;
  logic [W-2:0]     a_mag, b_mag, x_mag, y_mag;
  logic [XW-1:0]    x_ext, y_ext, y_al;
  logic [2*XW-1:0]  y_wide;
  logic             sp_hit;
  logic [W-1:0]     sp_word;
  logic [2:0]       sp_flags;

  always_comb begin
    a_s   = A_FP[W-1];
    b_s   = B_FP[W-1] ^ op_sub;
    a_e   = A_FP[W-2:MAN_W];
    b_e   = B_FP[W-2:MAN_W];
    a_cls = fp_classify(&a_e, ~|a_e, ~|A_FP[MAN_W-1:0]);
    b_cls = fp_classify(&b_e, ~|b_e, ~|B_FP[MAN_W-1:0]);
    a_mag = (a_cls == CLS_ZERO) ? '0 : A_FP[W-2:0];
    b_mag = (b_cls == CLS_ZERO) ? '0 : B_FP[W-2:0];
    swap  = b_mag > a_mag;
    x_s   = swap ? b_s : a_s;
    y_s   = swap ? a_s : b_s;
    x_mag = swap ? b_mag : a_mag;
    y_mag = swap ? a_mag : b_mag;
    x_e   = x_mag[W-2:MAN_W];
    y_e   = y_mag[W-2:MAN_W];
    x_ext = (x_mag == '0) ? '0 : {1'b1, x_mag[MAN_W-1:0], 3'b000};
    y_ext = (y_mag == '0) ? '0 : {1'b1, y_mag[MAN_W-1:0], 3'b000};
    shift  = x_e - y_e;
    y_wide = {y_ext, {XW{1'b0}}} >> shift;
    if (32'(shift) >= 32'(XW - 1)) y_al = {{(XW-1){1'b0}}, |y_ext};
    else                           y_al = {y_wide[2*XW-1:XW+1], y_wide[XW] | (|y_wide[XW-1:0])};

    sp_hit   = (a_cls == CLS_INF) || (a_cls == CLS_NAN) || (b_cls == CLS_INF) || (b_cls == CLS_NAN);
    sp_word  = '0;
    sp_flags = '0;
    if (a_cls == CLS_NAN || b_cls == CLS_NAN ||
        (a_cls == CLS_INF && b_cls == CLS_INF && a_s != b_s)) begin
      sp_word               = QNAN;
      sp_flags[FLG_INVALID] = 1'b1;
    end else if (a_cls == CLS_INF) begin
      sp_word = {a_s, EXP_ONES, {MAN_W{1'b0}}};
    end else begin
      sp_word = {b_s, EXP_ONES, {MAN_W{1'b0}}};
    end
  end

  logic             s1_valid, s1_sp, s1_sign, s1_zsign, s1_sub;
  logic [W-1:0]     s1_sp_word;
  logic [2:0]       s1_sp_flags;
  logic [EXP_W-1:0] s1_exp;
  logic [XW-1:0]    s1_x, s1_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0; s1_sp <= 1'b0; s1_sign <= 1'b0; s1_zsign <= 1'b0; s1_sub <= 1'b0;
      s1_sp_word <= '0; s1_sp_flags <= '0; s1_exp <= '0; s1_x <= '0; s1_y <= '0;
    end else if (advance) begin
      s1_valid    <= in_valid;
      s1_sp       <= sp_hit;
      s1_sp_word  <= sp_word;
      s1_sp_flags <= sp_flags;
      s1_sign     <= x_s;
      s1_zsign    <= x_s & y_s;
      s1_sub      <= x_s ^ y_s;
      s1_exp      <= x_e;
      s1_x        <= x_ext;
      s1_y        <= y_al;
    end
  end

  // ---------------- S2: add/subtract ----------------
  logic             s2_valid, s2_sp, s2_sign, s2_zsign;
  logic [W-1:0]     s2_sp_word;
  logic [2:0]       s2_sp_flags;
  logic [EXP_W-1:0] s2_exp;
  logic [XW:0]      s2_sum, sum_d;

  // |X| >= |Y| after the swap, so the difference never goes negative.
  assign sum_d = s1_sub ? ({1'b0, s1_x} - {1'b0, s1_y}) : ({1'b0, s1_x} + {1'b0, s1_y});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0; s2_sp <= 1'b0; s2_sign <= 1'b0; s2_zsign <= 1'b0;
      s2_sp_word <= '0; s2_sp_flags <= '0; s2_exp <= '0; s2_sum <= '0;
    end else if (advance) begin
      s2_valid    <= s1_valid;
      s2_sp       <= s1_sp;
      s2_sp_word  <= s1_sp_word;
      s2_sp_flags <= s1_sp_flags;
      s2_sign     <= s1_sign;
      s2_zsign    <= s1_zsign;
      s2_exp      <= s1_exp;
      s2_sum      <= sum_d;
    end
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic [CW-1:0]    lz;
  logic [XW-1:0]    norm;
  logic [EW-1:0]    e_norm, e_rnd;
  logic             up, e_neg;
  logic [MAN_W+1:0] rnd;
  logic [MAN_W-1:0] frac;
  logic [W-1:0]     res_word;
  logic [2:0]       res_flags;

  fp_lzc #(.WIDTH(XW), .CNT_W(CW)) u_lzc (
    .data  (s2_sum[XW-1:0]),
    .count (lz)
  );

  always_comb begin
    if (s2_sum[XW]) begin
      norm   = {s2_sum[XW:2], s2_sum[1] | s2_sum[0]};
      e_norm = {2'b00, s2_exp} + EW'(1);
    end else begin
      norm   = s2_sum[XW-1:0] << lz;
      e_norm = {2'b00, s2_exp} - EW'(lz);
    end
    up    = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd   = {1'b0, norm[XW-1:3]} + (MAN_W+2)'(up);
    e_rnd = e_norm + EW'(rnd[MAN_W+1]);
    frac  = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
    e_neg = e_rnd[EW-1];

    res_word  = {s2_sign, e_rnd[EXP_W-1:0], frac};
    res_flags = '0;
    res_flags[FLG_INEXACT] = |norm[2:0];
    if (s2_sp) begin
      res_word  = s2_sp_word;
      res_flags = s2_sp_flags;
    end else if (s2_sum == '0) begin
      res_word  = {s2_zsign, {(W-1){1'b0}}};
      res_flags = '0;
    end else if (!e_neg && e_rnd >= {2'b00, EXP_ONES}) begin
      res_word  = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
      res_flags = '0;
      res_flags[FLG_OVERFLOW] = 1'b1;
      res_flags[FLG_INEXACT]  = 1'b1;
    end else if (e_neg || e_rnd == '0) begin
      res_word  = {s2_sign, {(W-1){1'b0}}};
      res_flags = '0;
      res_flags[FLG_INEXACT] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0; sign <= 1'b0; exponent <= '0; mantissa <= '0; flags <= '0;
    end else if (advance) begin
      out_valid <= s2_valid;
      sign      <= res_word[W-1];
      exponent  <= res_word[W-2:MAN_W];
      mantissa  <= res_word[MAN_W-1:0];
      flags     <= res_flags;
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Bench for fp_add_pipe: directed vectors, backpressure, randomized traffic
// against an exact-integer reference model, and a mid-stream reset.
module tb_fp_add_pipe;

  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, op_sub = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, sign;
  logic [31:0] a_fp = '0, b_fp = '0;
  logic [7:0]  exponent;
  logic [22:0] mantissa;
  logic [2:0]  flags;

  always #5 clk = ~clk;

  fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A_FP(a_fp), .B_FP(b_fp), .op_sub(op_sub), .out_valid(out_valid),
    .out_ready(out_ready), .sign(sign), .exponent(exponent),
    .mantissa(mantissa), .flags(flags)
  );

  int n_checks = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [34:0] exp_q[$];
  int          cyc_q[$];
  bit          lat_q[$];
  bit          bp_mode = 1'b0, rnd_ready = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Exact reference: operands become wide integers on a common scale, the
  // sum is formed exactly and rounded to 24 significant bits by RNE.
  function automatic logic [34:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic sa, sb, sr, inexact;
    int ea, eb, el, p, sh, e;
    logic [23:0]  ma, mb;
    logic [127:0] fa, fb, m, rem, half, keep;
    sa = a[31]; sb = b[31] ^ sub;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) ||
        (ea == 255 && eb == 255 && sa != sb)) return {32'h7FC00000, 3'b100};
    if (ea == 255) return {sa, 8'hFF, 23'h0, 3'b000};
    if (eb == 255) return {sb, 8'hFF, 23'h0, 3'b000};
    ma = (ea == 0) ? 24'h0 : {1'b1, a[22:0]};
    mb = (eb == 0) ? 24'h0 : {1'b1, b[22:0]};
    if (ma == 0 && mb == 0) return {sa & sb, 31'h0, 3'b000};
    el = (ma == 0) ? eb : (mb == 0) ? ea : ((ea > eb) ? ea : eb);
    if (ma == 0) fa = '0; else if (el - ea > 64) fa = 128'd1; else fa = 128'(ma) << (64 - (el - ea));
    if (mb == 0) fb = '0; else if (el - eb > 64) fb = 128'd1; else fb = 128'(mb) << (64 - (el - eb));
    if (sa == sb) begin m = fa + fb; sr = sa; end
    else if (fa == fb) return {32'h0, 3'b000};
    else if (fa > fb) begin m = fa - fb; sr = sa; end
    else begin m = fb - fa; sr = sb; end
    p = 0;
    for (int i = 0; i < 128; i++) if (m[i]) p = i;
    sh   = p - 23;
    keep = m >> sh;
    rem  = m & ((128'd1 << sh) - 128'd1);
    half = 128'd1 << (sh - 1);
    inexact = (rem != 0);
    if (rem > half || (rem == half && keep[0])) keep = keep + 128'd1;
    if (keep[24]) begin keep = keep >> 1; p++; end
    e = el + p - 87;
    if (e >= 255) return {sr, 8'hFF, 23'h0, 3'b011};
    if (e < 1)    return {sr, 31'h0, 3'b001};
    return {sr, 8'(e), keep[22:0], 2'b00, inexact};
  endfunction

  function automatic logic [31:0] rand_fp(input logic [31:0] near);
    logic [31:0] v;
    int e;
    v = $urandom;
    case ($urandom_range(0, 9))
      0: case ($urandom_range(0, 5))
           0: v = 32'h7F800000;
           1: v = 32'hFF800000;
           2: v = 32'h7FC00001;
           3: v = 32'h00000000;
           4: v = 32'h80000000;
           default: v = {v[31], 8'h00, v[22:0]};
         endcase
      1, 2, 3: begin
        e = int'(near[30:23]) + int'($urandom_range(0, 4)) - 2;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        v[30:23] = 8'(e);
        if ($urandom_range(0, 3) == 0) v[22:0] = near[22:0] ^ 23'(1 << $urandom_range(0, 22));
      end
      4: v[30:23] = 8'($urandom_range(250, 254));
      5: v[30:23] = 8'($urandom_range(1, 4));
      default: if (v[30:23] == 8'hFF) v[30:23] = 8'h80;
    endcase
    return v;
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                      input logic [34:0] want, input bit lat);
    int c0;
    bit acc;
    a_fp = a; b_fp = b; op_sub = sub; in_valid = 1'b1;
    acc = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      acc = in_ready;
      c0  = cyc;
      @(posedge clk);
      #1;
      if (acc) begin
        exp_q.push_back(want); cyc_q.push_back(c0); lat_q.push_back(lat);
        return;
      end
    end
    check_eq("accept_timeout", acc, 1);
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(posedge clk);
    check_eq("drain", exp_q.size(), 0);
    #1;
  endtask

  logic [34:0] held, want_v;
  bit          stall_prev = 1'b0, lat_v;
  int          c_v;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_eq("stall_valid", out_valid, 1);
        check_eq("stall_hold", {sign, exponent, mantissa, flags}, held);
      end
      check_eq("in_ready", in_ready, !(out_valid && !out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_eq("unexpected_out", out_valid, 0);
        else begin
          want_v = exp_q.pop_front(); c_v = cyc_q.pop_front(); lat_v = lat_q.pop_front();
          check_eq("result", {sign, exponent, mantissa, flags}, want_v);
          if (lat_v) check_eq("latency", cyc - c_v, 3);
        end
      end
      stall_prev = out_valid && !out_ready;
      held = {sign, exponent, mantissa, flags};
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (bp_mode) out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
    else if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] da[11] = '{32'h40E80000, 32'h40C00000, 32'h42820000, 32'h40E00000, 32'h3F800000,
                          32'h3F800001, 32'h7F7FFFFF, 32'h7F800000, 32'h7F800000, 32'h80000000,
                          32'h00000000};
  logic [31:0] db[11] = '{32'h3EC00000, 32'h40E00000, 32'hC27C0000, 32'h40E00000, 32'h33800000,
                          32'h33800000, 32'h7F7FFFFF, 32'hFF800000, 32'h3F800000, 32'h80000000,
                          32'h80000000};
  logic        ds[11] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
  logic [34:0] dx[11] = '{{32'h40F40000, 3'b000}, {32'h41500000, 3'b000}, {32'h40000000, 3'b000},
                          {32'h00000000, 3'b000}, {32'h3F800000, 3'b001}, {32'h3F800002, 3'b001},
                          {32'h7F800000, 3'b011}, {32'h7FC00000, 3'b100}, {32'h7F800000, 3'b000},
                          {32'h80000000, 3'b000}, {32'h00000000, 3'b000}};

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_sign", sign, 0);
    check_eq("rst_exponent", exponent, 0);
    check_eq("rst_mantissa", mantissa, 0);
    check_eq("rst_flags", flags, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("ready_after_reset", in_ready, 1);

    for (int i = 0; i < 11; i++) send(da[i], db[i], ds[i], dx[i], 1'b1);
    in_valid = 1'b0;
    wait_drain();

    bp_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ra = rand_fp(32'h3F800000); rb = rand_fp(ra); rs = 1'($urandom_range(0, 1));
      send(ra, rb, rs, ref_add(ra, rb, rs), 1'b0);
    end
    in_valid = 1'b0;
    wait_drain();
    bp_mode = 1'b0;

    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ra = rand_fp(32'h3F800000); rb = rand_fp(ra); rs = 1'($urandom_range(0, 1));
      send(ra, rb, rs, ref_add(ra, rb, rs), 1'b0);
      if ($urandom_range(0, 4) == 0) begin in_valid = 1'b0; @(posedge clk); #1; end
    end
    in_valid = 1'b0;
    wait_drain();
    rnd_ready = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) send(da[i], db[i], ds[i], dx[i], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_valid", out_valid, 0);
    exp_q.delete(); cyc_q.delete(); lat_q.delete();
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_eq("no_stale_valid", out_valid, 0);
    send(da[0], db[0], ds[0], dx[0], 1'b1);
    in_valid = 1'b0;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
